// File: rtl/stepper_phase_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_phase_sequencer_if
//  Description : Move-command handshake bundle for the stepper phase sequencer.
//                The master issues {dir, steps, half} qualified by cmd_valid.
//                The slave (sequencer) returns cmd_ready.
//  Revision    : 1.0  initial release
// ============================================================================
interface stepper_phase_sequencer_if #(
  parameter int STEP_W = 16
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_half;

  // Command source side
  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    output cmd_half,
    input  cmd_ready
  );

  // Sequencer side
  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    input  cmd_half,
    output cmd_ready
  );

endinterface : stepper_phase_sequencer_if
`default_nettype wire

// File: rtl/stepper_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_phase_sequencer
//  Description : Turns each rising edge of the prescaler step clock into one
//                motor step, driving the four coil phases {A,B,C,D}. Accepts
//                move commands (dir, count, half/full mode) over valid/ready
//                and tracks absolute position in half-step units.
//  Build macro : STEPPER_IDLE_RELEASE_EN - when defined, the coils are
//                de-energized (phase = 0000) whenever the sequencer is idle;
//                the table index is kept so the next move resumes from it.
//  Revision    : 1.0  initial release
// ============================================================================
module stepper_phase_sequencer #(
  parameter int STEP_W = 16,
  parameter int POS_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,         // synchronous, active low
  input  logic                      step_clk,
  stepper_phase_sequencer_if.slave  cmd,
  input  logic                      abort,
  output logic [3:0]                phase,
  output logic                      busy,
  output logic                      done,
  output logic [STEP_W-1:0]         steps_left,
  output logic [POS_W-1:0]          position
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Coil pattern shown after reset: coils off in release builds, otherwise
  // the pattern of table index 0 so the rotor is held in a known detent.
`ifdef STEPPER_IDLE_RELEASE_EN
  localparam logic [3:0] PHASE_RST = 4'b0000;
`else
  localparam logic [3:0] PHASE_RST = 4'b1000;
`endif

  // Eight-entry half-step table; full stepping visits every other entry.
  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t            state_q,  state_d;
  logic              step_q,   step_d;     // step_clk delayed one clk
  logic              tick_q,   tick_d;     // registered rising-edge detect
  logic [2:0]        idx_q,    idx_d;      // phase table index
  logic [POS_W-1:0]  pos_q,    pos_d;
  logic [STEP_W-1:0] left_q,   left_d;
  logic              dir_q,    dir_d;      // latched at command acceptance
  logic              half_q,   half_d;     // latched at command acceptance
  logic              done_q,   done_d;
  logic              busy_q,   busy_d;
  logic [3:0]        phase_q,  phase_d;

  // Signed per-step increments derived from the latched mode/direction
  logic [2:0]        idx_step;
  logic [POS_W-1:0]  pos_step;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      step_q  <= 1'b0;
      tick_q  <= 1'b0;
      idx_q   <= 3'd0;
      pos_q   <= '0;
      left_q  <= '0;
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      phase_q <= PHASE_RST;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      left_q  <= left_d;
      dir_q   <= dir_d;
      half_q  <= half_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      phase_q <= phase_d;
    end
  end

  // Step increments: +/-1 in half mode, +/-2 in full mode. The index and the
  // position move by the same signed amount; the index simply wraps mod 8.
  always_comb begin
    idx_step = 3'd0;
    pos_step = '0;
    if (half_q) begin
      idx_step = dir_q ? 3'd1 : 3'd7;
      pos_step = POS_W'(1);
    end else begin
      idx_step = dir_q ? 3'd2 : 3'd6;
      pos_step = POS_W'(2);
    end
    if (!dir_q) begin
      pos_step = -pos_step;
    end
  end

  // Next-state logic: command acceptance, stepping, abort and completion
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    left_d  = left_q;
    dir_d   = dir_q;
    half_d  = half_q;
    step_d  = step_clk;
    // A tick is only kept when it is detected while a move is running, so
    // edges seen in IDLE/FINISH (including the acceptance edge) are dropped.
    tick_d  = step_clk && !step_q && (state_q == ST_RUN);

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          dir_d   = cmd.cmd_dir;
          half_d  = cmd.cmd_half;
          left_d  = cmd.cmd_steps;
          state_d = (cmd.cmd_steps != '0) ? ST_RUN : ST_FINISH;
        end
      end
      ST_RUN: begin
        // Abort has priority over a coinciding tick: no step is taken and
        // the remaining count is left visible.
        if (abort) begin
          state_d = ST_FINISH;
        end else if (tick_q) begin
          idx_d  = idx_q + idx_step;
          pos_d  = pos_q + pos_step;
          left_d = left_q - STEP_W'(1);
          if (left_q == STEP_W'(1)) begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered versions of the next-state decode so that they
    // line up with the state they describe.
    done_d = (state_d == ST_FINISH);
    busy_d = (state_d != ST_IDLE);
`ifdef STEPPER_IDLE_RELEASE_EN
    phase_d = (state_d == ST_IDLE) ? 4'b0000 : phase_of(idx_d);
`else
    phase_d = phase_of(idx_d);
`endif
  end

  // Ready is a pure state decode so a waiting command is taken the same cycle
  assign cmd.cmd_ready = (state_q == ST_IDLE);

  assign phase      = phase_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = left_q;
  assign position   = pos_q;

endmodule : stepper_phase_sequencer
`default_nettype wire
